// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch unit: redirect-mode selects and FSM states.
package fetch_pkg;

    typedef enum logic [1:0] {
        SEL_NEXT = 2'd0,
        SEL_SKIP = 2'd1,
        SEL_JR   = 2'd2,
        SEL_REL  = 2'd3
    } redir_sel_e;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of redirect, decode handshake and instruction-memory write signals.
interface fetch_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              redir_valid;
    logic [1:0]        redir_sel;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] redir_target;
    logic [DATA_W-1:0] redir_offset;

    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [DATA_W-1:0] im_wdata;

    modport master (
        output redir_valid, redir_sel, redir_pc, redir_target, redir_offset,
        output instr_ready, im_we, im_waddr, im_wdata,
        input  instr, instr_pc, instr_valid
    );

    modport slave (
        input  redir_valid, redir_sel, redir_pc, redir_target, redir_offset,
        input  instr_ready, im_we, im_waddr, im_wdata,
        output instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instr, pc} entries; flush empties it.
module fetch_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             pop_eff;
    logic             push_eff;

    assign empty_o  = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_eff  = pop_i && !empty_o;
    assign push_eff = push_i && (!full || pop_eff);
    assign head_o   = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
        end
    end

    // Storage carries no reset; entries are only visible once counted.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (push_eff && !flush_i && (wr_ptr_q == PTR_W'(gi)))
                mem_q[gi] <= push_data_i;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// PC register, next-PC mux, synchronous instruction memory and prefetch queue
// feeding decode through a valid/ready handshake.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int IM_DEPTH = 1024,
    parameter int Q_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.slave       bus,
    output logic [ADDR_W-1:0] fetch_pc_o
);
    localparam int IDX_W   = $clog2(IM_DEPTH);
    localparam int CNT_W   = $clog2(Q_DEPTH) + 1;
    localparam int ENTRY_W = DATA_W + ADDR_W;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] imem [IM_DEPTH];

    logic [ADDR_W-1:0]  offset_ext;
    logic [ADDR_W-1:0]  target;
    logic [CNT_W-1:0]   q_count;
    logic               q_empty;
    logic [ENTRY_W-1:0] q_head;
    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W-1:0]   occupancy;

    if (DATA_W >= ADDR_W) begin : g_off_trunc
        assign offset_ext = bus.redir_offset[ADDR_W-1:0];
    end else begin : g_off_sext
        assign offset_ext = {{(ADDR_W-DATA_W){bus.redir_offset[DATA_W-1]}}, bus.redir_offset};
    end

    if (ADDR_W > IDX_W) begin : g_alias
        logic unused_waddr_hi;
        assign unused_waddr_hi = ^bus.im_waddr[ADDR_W-1:IDX_W];
    end

    always_comb begin
        target = bus.redir_pc + ADDR_W'(1);
        case (redir_sel_e'(bus.redir_sel))
            SEL_NEXT: target = bus.redir_pc + ADDR_W'(1);
            SEL_SKIP: target = bus.redir_pc + ADDR_W'(2);
            SEL_JR:   target = bus.redir_target;
            SEL_REL:  target = bus.redir_pc + offset_ext;
            default:  target = bus.redir_pc + ADDR_W'(1);
        endcase
    end

    // Entries queued plus the read in flight must never exceed the queue size,
    // unless a pop this cycle makes room for the read that lands next cycle.
    assign pop       = !q_empty && bus.instr_ready;
    assign occupancy = q_count + CNT_W'(inflight_q);
    assign issue     = !bus.redir_valid && (state_q != BOOT) &&
                       ((occupancy < CNT_W'(Q_DEPTH)) || pop);
    assign push      = inflight_q && !bus.redir_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redir_valid)
            fetch_pc_d = target;
        else if (issue)
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (bus.redir_valid) begin
                state_q    <= FLUSH;
                inflight_q <= 1'b0;
            end else if (state_q == BOOT) begin
                state_q    <= RUN;
                inflight_q <= 1'b0;
            end else begin
                state_q       <= issue ? RUN : HOLD;
                inflight_q    <= issue;
                inflight_pc_q <= issue ? fetch_pc_q : inflight_pc_q;
            end
        end
    end

    // Read-first block RAM: a same-edge write to the read index returns old data.
    always_ff @(posedge clk) begin
        if (bus.im_we)
            imem[bus.im_waddr[IDX_W-1:0]] <= bus.im_wdata;
        if (issue)
            rdata_q <= imem[fetch_pc_q[IDX_W-1:0]];
    end

    fetch_queue #(
        .W     (ENTRY_W),
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.redir_valid),
        .push_i      (push),
        .push_data_i ({rdata_q, inflight_pc_q}),
        .pop_i       (pop),
        .head_o      (q_head),
        .count_o     (q_count),
        .empty_o     (q_empty)
    );

    assign bus.instr_valid = !q_empty;
    assign bus.instr       = q_empty ? '0 : q_head[ENTRY_W-1:ADDR_W];
    assign bus.instr_pc    = q_empty ? '0 : q_head[ADDR_W-1:0];
    assign fetch_pc_o      = fetch_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] fetch_pc;
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    fetch_unit #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .IM_DEPTH (1024),
        .Q_DEPTH  (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fetch_pc_o (fetch_pc)
    );

    function automatic logic [15:0] word(input int a);
        if (a == 0)      return 16'h06A0;
        if (a == 1)      return 16'h2004;
        if (a == 2)      return 16'h060A;
        if (a == 'h3FF)  return 16'h0BAD;
        return 16'h1000 + 16'(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            $display("ok   %s: 0x%0h", tag, obs);
        end else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [15:0] pc, input logic [15:0] ins);
        check({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, ".pc"},    32'(bus.instr_pc),    32'(pc));
        check({tag, ".instr"}, 32'(bus.instr),       32'(ins));
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [15:0] pc,
                            input logic [15:0] tgt, input logic [15:0] off);
        bus.redir_valid  = 1'b1;
        bus.redir_sel    = sel;
        bus.redir_pc     = pc;
        bus.redir_target = tgt;
        bus.redir_offset = off;
    endtask

    initial begin
        bus.redir_valid  = 1'b0;
        bus.redir_sel    = 2'd0;
        bus.redir_pc     = '0;
        bus.redir_target = '0;
        bus.redir_offset = '0;
        bus.instr_ready  = 1'b0;
        bus.im_we        = 1'b0;
        bus.im_waddr     = '0;
        bus.im_wdata     = '0;

        tick();
        check("reset.valid",    32'(bus.instr_valid), 32'd0);
        check("reset.instr",    32'(bus.instr),       32'd0);
        check("reset.instr_pc", 32'(bus.instr_pc),    32'd0);
        check("reset.fetch_pc", 32'(fetch_pc),        32'd0);

        // Preload memory while reset is held; memory is not reset.
        bus.im_we = 1'b1;
        for (int a = 0; a < 17; a++) begin
            bus.im_waddr = (a == 16) ? 16'h03FF : 16'(a);
            bus.im_wdata = word((a == 16) ? 'h3FF : a);
            tick();
        end
        bus.im_we = 1'b0;

        rst = 1'b0;
        bus.instr_ready = 1'b1;
        check("boot.state", 32'(dut.state_q), 32'(BOOT));
        check("boot.valid", 32'(bus.instr_valid), 32'd0);
        tick();
        check("boot1.valid", 32'(bus.instr_valid), 32'd0);
        check("boot1.state", 32'(dut.state_q), 32'(RUN));
        tick();
        check("boot2.valid", 32'(bus.instr_valid), 32'd0);
        check("boot2.fetch_pc", 32'(fetch_pc), 32'd1);
        tick(); check_head("seq0", 16'd0, 16'h06A0);
        tick(); check_head("seq1", 16'd1, 16'h2004);
        tick(); check_head("seq2", 16'd2, 16'h060A);

        // Back-pressure: queue fills, head held, FSM parks in HOLD.
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_head("stall", 16'd2, 16'h060A);
        end
        check("stall.state",    32'(dut.state_q), 32'(HOLD));
        check("stall.count",    32'(dut.q_count), 32'd2);
        check("stall.fetch_pc", 32'(fetch_pc),    32'd4);
        bus.instr_ready = 1'b1;
        tick(); check_head("resume3", 16'd3, 16'h1003);
        bus.instr_ready = 1'b0;
        tick(); check_head("hold3", 16'd3, 16'h1003);
        check("hold34.count", 32'(dut.q_count), 32'd2);

        // Jump-register redirect with pc 3,4 queued.
        bus.instr_ready = 1'b1;
        redirect(2'(SEL_JR), 16'd0, 16'd5, 16'd0);
        tick();
        bus.redir_valid = 1'b0;
        check("jr.flush_valid", 32'(bus.instr_valid), 32'd0);
        check("jr.fetch_pc",    32'(fetch_pc),        32'd5);
        check("jr.state",       32'(dut.state_q),     32'(FLUSH));
        tick();
        check("jr.gap_valid", 32'(bus.instr_valid), 32'd0);
        tick(); check_head("jr5", 16'd5, 16'h1005);
        tick(); check_head("jr6", 16'd6, 16'h1006);

        // Relative redirect with negative offset: 2 + (-2) = 0.
        redirect(2'(SEL_REL), 16'h0002, 16'd0, 16'hFFFE);
        tick();
        bus.redir_valid = 1'b0;
        check("rel.fetch_pc", 32'(fetch_pc), 32'd0);
        tick();
        tick(); check_head("rel0", 16'h0000, 16'h06A0);

        // Sequential redirect wrapping past all-ones.
        redirect(2'(SEL_NEXT), 16'hFFFF, 16'd0, 16'd0);
        tick();
        bus.redir_valid = 1'b0;
        check("next.fetch_pc", 32'(fetch_pc), 32'd0);
        tick();
        tick(); check_head("nextwrap", 16'h0000, 16'h06A0);

        // fetch_pc wraps all-ones -> 0; index aliasing of 0xFFFF -> 0x3FF.
        redirect(2'(SEL_JR), 16'd0, 16'hFFFF, 16'd0);
        tick();
        bus.redir_valid = 1'b0;
        check("jrmax.fetch_pc", 32'(fetch_pc), 32'hFFFF);
        tick();
        check("wrap.fetch_pc", 32'(fetch_pc), 32'd0);
        tick(); check_head("alias", 16'hFFFF, 16'h0BAD);
        tick(); check_head("wrap0", 16'h0000, 16'h06A0);

        // Write address 7 on the very edge that issues the read of 7.
        for (int k = 1; k <= 7; k++) begin
            if (k == 6) begin
                bus.im_we    = 1'b1;
                bus.im_waddr = 16'd7;
                bus.im_wdata = 16'hA000;
            end
            tick();
            bus.im_we = 1'b0;
            if (k == 6) check("rfw.fetch_pc", 32'(fetch_pc), 32'd8);
            check_head("stream", 16'(k), word(k));
        end

        redirect(2'(SEL_JR), 16'd0, 16'd7, 16'd0);
        tick();
        bus.redir_valid = 1'b0;
        tick();
        tick(); check_head("refetch7", 16'd7, 16'hA000);

        // Asynchronous reset with a full queue.
        bus.instr_ready = 1'b0;
        tick();
        check("prerst.count", 32'(dut.q_count), 32'd2);
        rst = 1'b1;
        #1;
        check("arst.valid",    32'(bus.instr_valid), 32'd0);
        check("arst.fetch_pc", 32'(fetch_pc),        32'd0);
        check("arst.instr",    32'(bus.instr),       32'd0);
        tick();
        check("arst.state", 32'(dut.state_q), 32'(BOOT));
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        check("rboot1.valid", 32'(bus.instr_valid), 32'd0);
        tick();
        check("rboot2.valid", 32'(bus.instr_valid), 32'd0);
        tick(); check_head("restart0", 16'd0, 16'h06A0);
        tick(); check_head("restart1", 16'd1, 16'h2004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised successor to the phase-1 PC/next-PC-mux/instruction-memory datapath. Holds the PC, selects the next PC (sequential, skip, jump-register, PC-relative), reads a synchronous instruction memory and delivers instructions with their PC through a small prefetch queue and a valid/ready handshake to decode. Redirects flush all queued and in-flight fetches. Sits between the control unit (redirect source) and the decode stage.

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 16, PC width in bits; word-addressed, PC+1 = next instruction
IM_DEPTH, 1024, instruction memory words (power of 2); index = PC[log2(IM_DEPTH)-1:0]
Q_DEPTH, 2, prefetch queue entries (power of 2, >= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
redir_valid  in  1  redirect request this cycle
redir_sel  in  2  0 = PC+1 of redir_pc, 1 = PC+2 of redir_pc (skip), 2 = jr (redir_target), 3 = relative (redir_pc + sext(redir_offset))
redir_pc  in  ADDR_W  PC of the instruction causing the redirect
redir_target  in  ADDR_W  absolute jump-register target
redir_offset  in  DATA_W  signed offset for relative mode
instr  out  DATA_W  instruction at queue head
instr_pc  out  ADDR_W  PC of instr
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts head
im_we  in  1  instruction-memory write enable
im_waddr  in  ADDR_W  write address (low index bits used)
im_wdata  in  DATA_W  write data
fetch_pc  out  ADDR_W  address of next read to be issued (debug)

Behaviour:
- Reset (async): fetch_pc = RESET_PC, queue empty, in-flight cleared, instr_valid = 0, instr = 0, instr_pc = 0, FSM = BOOT.
- FSM: BOOT -> RUN on first clock after Reset deasserts (no read in BOOT). RUN: issue a read when (count + inflight) < Q_DEPTH or a pop occurs this cycle; otherwise go to HOLD. HOLD -> RUN when a slot frees. Any state -> FLUSH on redir_valid; FLUSH -> RUN next cycle.
- Memory read latency 1: read issued at edge t with fetch_pc; data plus that PC pushed into the queue at edge t+1 unless killed. fetch_pc increments by 1 on each issue.
- Handshake: transfer when instr_valid && instr_ready; head pops at that edge. instr/instr_pc stable while valid && !ready.
- Redirect at edge t: the transfer at edge t (if valid && ready) still counts; queue cleared and in-flight read killed; fetch_pc <= target. Read of target issued at edge t+1; instr_valid = 1 with instr_pc = target after edge t+2. No read issued in the redirect cycle.
- Target arithmetic modulo 2^ADDR_W: redir_offset sign-extended or truncated to ADDR_W, wraps both ways; fetch_pc wraps from all-ones to 0.
- Memory index uses low bits only; PCs beyond IM_DEPTH alias silently; no error flag.
- IM write at edge t: a read of the same index at edge t returns old data (read-first); reads at t+1 and later return new data. Writes do not flush the queue.
- Reset mid-operation: all state cleared immediately; memory contents retained.
- Queue never overflows; no push into a full queue (guaranteed by the issue rule).

Decomposition:
- Package fetch_pkg: redir_sel encodings (SEL_NEXT, SEL_SKIP, SEL_JR, SEL_REL), FSM state typedef (BOOT, RUN, HOLD, FLUSH).
- Sub-module fetch_queue: parametrised sync FIFO (DATA_W+ADDR_W wide, Q_DEPTH), with push, pop, flush, count. Memory and next-PC mux stay in fetch_unit.

Test Plan:
- Reset with memory preloaded 0x06A0, 0x2004, 0x060A at 0..2, instr_ready = 1 -> after BOOT, instr_pc 0, 1, 2 on consecutive cycles with matching instr; instr_valid was 0 during reset and BOOT.
- instr_ready = 0 for 5 cycles -> queue fills to Q_DEPTH, FSM HOLD, instr/instr_pc held, no PC skipped after ready returns (pcs strictly consecutive).
- Redirect sel = 2, redir_target = 5 while queue holds pc 3, 4 -> pcs 3/4 never delivered after the redirect edge; next delivered instr_pc = 5 exactly 2 cycles later.
- Redirect sel = 3, redir_pc = 0x0002, redir_offset = 0xFFFE -> next instr_pc = 0x0000; redir_pc = 0xFFFF, sel = 0 -> instr_pc = 0x0000 (wrap).
- im_we to address 7 with 0xA000 in the same cycle as a read of 7 -> old word delivered; refetch of 7 after a redirect -> 0xA000.
- Assert Reset for one cycle mid-stream with a full queue -> instr_valid drops immediately (async), fetch restarts at RESET_PC with no stale entries delivered.
